// File: rtl/rf_pkg.sv
// Shared types for the register-file write path.
//   XLEN    : data width of one register
//   REG_AW  : register address width (32 architectural registers)
//   NREGS   : number of architectural registers
//   wb_entry_t : one buffered write (valid, destination, data)
package rf_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order load-result buffer for the write-back stage.
// Ports:
//   clk, rst_n          clock, async active-low reset (empties the buffer)
//   push, push_entry    enqueue one entry (caller guarantees !full)
//   pop                 dequeue the head (caller guarantees !empty)
//   kill_en, kill_rd    clear valid on every stored entry whose rd matches
//   head                entry at the read pointer
//   empty, full         occupancy flags (pointers carry an extra wrap bit)
//   live, live_rd       per-slot "occupied and still valid" plus its rd,
//                       used to build the pending-write mask
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  wb_entry_t                     push_entry,
  input  logic                          pop,
  input  logic                          kill_en,
  input  logic [REG_AW-1:0]             kill_rd,
  output wb_entry_t                     head,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              live,
  output logic [DEPTH-1:0][REG_AW-1:0]  live_rd
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW:0]     wptr, rptr;
  logic [AW:0]     count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Kill stale slots too; they are rewritten before being read again.
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && mem[i].rd == kill_rd) mem[i].valid <= 1'b0;
      // The incoming entry already carries its own kill decision, so a
      // push into a matching slot must override the clear above.
      if (push) begin
        mem[wptr[AW-1:0]] <= push_entry;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_comb begin
    live    = '0;
    live_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the read pointer is
      // below the current count.
      automatic logic [AW-1:0] off = AW'(i) - rptr[AW-1:0];
      live[i]    = ({1'b0, off} < count) && mem[i].valid;
      live_rd[i] = mem[i].rd;
    end
  end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port driver. Merges single-cycle ALU results with
// load results (buffered in wb_fifo when they collide) and issues at most
// one registered RF write per cycle. Also exports a pending-write mask.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   alu_valid, alu_rd, alu_data        ALU result, no backpressure
//   ld_valid, ld_ready, ld_rd, ld_data load result handshake
//   rf_we, rf_wr, rf_wd                registered RF write port
//   pending_mask                       bit i set while a write to xi is
//                                      queued or being driven (bit 0 = 0)
// Optional (macro RF_WB_FWD_EN): fwd_rR1/2 in, fwd_hit1/2 and
//   fwd_data1/2 out, bypassing the value currently driven to the RF.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr,
  output logic [XLEN-1:0]   rf_wd,
  output logic [NREGS-1:0]  pending_mask
`ifdef RF_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] fwd_rR1,
  input  logic [REG_AW-1:0] fwd_rR2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
`endif
);
  wb_entry_t                   push_entry, head;
  logic                        push, pop, empty, full;
  logic [DEPTH-1:0]            live;
  logic [DEPTH-1:0][REG_AW-1:0] live_rd;
  logic                        alu_w, ld_live;
  logic                        nxt_we;
  logic [REG_AW-1:0]           nxt_wr;
  logic [XLEN-1:0]             nxt_wd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (alu_w),
    .kill_rd    (alu_rd),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .live       (live),
    .live_rd    (live_rd)
  );

  // Full is sampled before this cycle's pop: the freed slot is not refilled
  // in the same cycle.
  assign ld_ready = !full;
  assign alu_w    = alu_valid && (alu_rd != '0);
  // x0 loads are accepted but never enter the buffer.
  assign ld_live  = ld_valid && ld_ready && (ld_rd != '0);

  always_comb begin
    nxt_we     = 1'b0;
    nxt_wr     = rf_wr;
    nxt_wd     = rf_wd;
    pop        = 1'b0;
    push       = 1'b0;
    // The ALU result is always the younger instruction, so a same-rd load
    // arriving alongside it is buffered already dead.
    push_entry = '{valid: !(alu_w && ld_rd == alu_rd), rd: ld_rd, data: ld_data};
    if (alu_w) begin
      nxt_we = 1'b1;
      nxt_wr = alu_rd;
      nxt_wd = alu_data;
      push   = ld_live;
    end else if (!empty) begin
      // A killed head still pops, it just doesn't write.
      pop    = 1'b1;
      nxt_we = head.valid;
      if (head.valid) begin
        nxt_wr = head.rd;
        nxt_wd = head.data;
      end
      push   = ld_live;
    end else if (ld_live) begin
      nxt_we = 1'b1;
      nxt_wr = ld_rd;
      nxt_wd = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wr <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= nxt_we;
      rf_wr <= nxt_wr;
      rf_wd <= nxt_wd;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i]) pending_mask[live_rd[i]] = 1'b1;
    if (rf_we) pending_mask[rf_wr] = 1'b1;
    pending_mask[0] = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  assign fwd_hit1  = rf_we && (rf_wr == fwd_rR1) && (fwd_rR1 != '0);
  assign fwd_hit2  = rf_we && (rf_wr == fwd_rR2) && (fwd_rR2 != '0);
  assign fwd_data1 = rf_wd;
  assign fwd_data2 = rf_wd;
`endif
endmodule
